// File: rtl/lsu_tlbdp_rdq.sv
// ---------------------------------------------------------------------------
// lsu_tlbdp_rdq
//   Read-return datapath for TLB tag/data reads on the LSU ASI path. Reads
//   are captured in stage 1, where their parity is checked and a 64b result
//   is formatted. The result is written into a small FIFO that drives the
//   ASI return bus through a valid/ready handshake. Parity errors update
//   per-thread saturating counters and a sticky first-error log.
//
//   Optional feature macro: LSU_TLBDP_ERRINJ_EN (parity error injection).
//
// Ports
//   rclk, arst_l            clock, asynchronous active-low reset
//   rd_vld / rd_rdy         read-return handshake into stage 1
//   rd_is_data, rd_tid      read type (1 = data) and requesting thread
//   tlb_tag, tlb_data       raw TLB words, MSB is the stored parity bit
//   inj_arm, inj_is_data    (LSU_TLBDP_ERRINJ_EN only) arm a parity flip
//   out_vld / out_rdy       queue head handshake
//   out_data, out_tid       formatted result and its thread
//   out_perr                head carried a parity error
//   ecnt                    per-thread error counts, thread 0 in the LSBs
//   elog_vld/tid/is_data    sticky first-error log
//   err_clr, elog_clr       counter clears (per thread) and log clear
// ---------------------------------------------------------------------------
module lsu_tlbdp_rdq #(
    parameter int NUM_THR  = 4,
    parameter int TAG_W    = 59,
    parameter int DATA_W   = 43,
    parameter int SEL_LSB  = 13,
    parameter int OQ_DEPTH = 2,
    parameter int ECNT_W   = 4,
    parameter int TID_W    = $clog2(NUM_THR)
) (
    input  logic                      rclk,
    input  logic                      arst_l,
    input  logic                      rd_vld,
    output logic                      rd_rdy,
    input  logic                      rd_is_data,
    input  logic [TID_W-1:0]          rd_tid,
    input  logic [TAG_W-1:0]          tlb_tag,
    input  logic [DATA_W-1:0]         tlb_data,
`ifdef LSU_TLBDP_ERRINJ_EN
    input  logic                      inj_arm,
    input  logic                      inj_is_data,
`endif
    output logic                      out_vld,
    input  logic                      out_rdy,
    output logic [63:0]               out_data,
    output logic [TID_W-1:0]          out_tid,
    output logic                      out_perr,
    output logic [NUM_THR*ECNT_W-1:0] ecnt,
    output logic                      elog_vld,
    output logic [TID_W-1:0]          elog_tid,
    output logic                      elog_is_data,
    input  logic [NUM_THR-1:0]        err_clr,
    input  logic                      elog_clr
);

    localparam int WORD_W = (TAG_W > DATA_W) ? TAG_W : DATA_W;
    localparam int PTR_W  = (OQ_DEPTH > 1) ? $clog2(OQ_DEPTH) : 1;
    localparam int OCC_W  = PTR_W + 1;

    logic              s1_vld;
    logic              s1_is_data;
    logic [TID_W-1:0]  s1_tid;
    logic [WORD_W-1:0] s1_word;
    logic              s1_inj;
    logic              s1_perr;
    logic [63:0]       s1_fmt;
    logic [2:0]        pgsz;

    logic [63:0]       q_data [OQ_DEPTH];
    logic [TID_W-1:0]  q_tid  [OQ_DEPTH];
    logic              q_perr [OQ_DEPTH];
    logic [PTR_W-1:0]  wptr, rptr;
    logic [OCC_W-1:0]  occ;
    logic              full, push, pop, take;
    logic              inj_hit;

    logic [ECNT_W-1:0] cnt [NUM_THR];

    // Handshake terms. Stage 1 may hold its entry when the queue is full and
    // nothing pops; a pop frees a slot in the same cycle, so rd_rdy can stay
    // high at steady state without a bubble.
    assign out_vld = (occ != '0);
    assign full    = (occ == OCC_W'(OQ_DEPTH));
    assign pop     = out_vld & out_rdy;
    assign push    = s1_vld & (~full | pop);
    assign rd_rdy  = (({1'b0, occ} + (OCC_W+1)'(s1_vld)) < (OCC_W+1)'(OQ_DEPTH)) | pop;
    assign take    = rd_vld & rd_rdy;

`ifdef LSU_TLBDP_ERRINJ_EN
    logic inj_armed;
    logic inj_type;

    // Injection arm: one flip per arm, consumed by the next capture of the
    // armed type; arming again while armed is ignored.
    assign inj_hit = inj_armed & take & (rd_is_data == inj_type);

    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            inj_armed <= 1'b0;
            inj_type  <= 1'b0;
        end else if (inj_hit) begin
            inj_armed <= 1'b0;
        end else if (inj_arm && !inj_armed) begin
            inj_armed <= 1'b1;
            inj_type  <= inj_is_data;
        end
    end
`else
    assign inj_hit = 1'b0;
`endif

    // Stage 1 capture: raw word, type and thread. The entry stays valid
    // until it has been pushed into the queue.
    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            s1_vld     <= 1'b0;
            s1_is_data <= 1'b0;
            s1_tid     <= '0;
            s1_word    <= '0;
            s1_inj     <= 1'b0;
        end else if (take) begin
            s1_vld     <= 1'b1;
            s1_is_data <= rd_is_data;
            s1_tid     <= rd_tid;
            s1_word    <= rd_is_data ? WORD_W'(tlb_data) : WORD_W'(tlb_tag);
            s1_inj     <= inj_hit;
        end else if (push) begin
            s1_vld     <= 1'b0;
        end
    end

    // Stage 1 parity check and result formatting. The page size comes from
    // the three select bits of a data word and sits in the top bits.
    always_comb begin
        pgsz[0] = s1_word[SEL_LSB];
        pgsz[1] = ~s1_word[SEL_LSB+2] & s1_word[SEL_LSB+1] & s1_word[SEL_LSB];
        pgsz[2] =  s1_word[SEL_LSB+2] & s1_word[SEL_LSB+1] & s1_word[SEL_LSB];
        if (s1_is_data) begin
            s1_perr = ^s1_word[DATA_W-2:0] ^ s1_word[DATA_W-1] ^ s1_inj;
            s1_fmt  = {pgsz, 61'(s1_word[DATA_W-2:0])};
        end else begin
            s1_perr = ^s1_word[TAG_W-2:0] ^ s1_word[TAG_W-1] ^ s1_inj;
            s1_fmt  = 64'(s1_word[TAG_W-2:0]);
        end
    end

    // Queue storage. Contents need no reset: the pointers and occupancy
    // decide what is visible, and outputs are forced to zero when empty.
    always_ff @(posedge rclk) begin
        if (push) begin
            q_data[wptr] <= s1_fmt;
            q_tid[wptr]  <= s1_tid;
            q_perr[wptr] <= s1_perr;
        end
    end

    // Queue pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            wptr <= '0;
            rptr <= '0;
            occ  <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            if (push && !pop)      occ <= occ + 1'b1;
            else if (pop && !push) occ <= occ - 1'b1;
        end
    end

    assign out_data = out_vld ? q_data[rptr] : '0;
    assign out_tid  = out_vld ? q_tid[rptr]  : '0;
    assign out_perr = out_vld & q_perr[rptr];

    // Per-thread saturating error counters, bumped when an erroneous entry
    // enters the queue. A clear in the same cycle takes priority.
    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            for (int t = 0; t < NUM_THR; t++) cnt[t] <= '0;
        end else begin
            for (int t = 0; t < NUM_THR; t++) begin
                if (err_clr[t])
                    cnt[t] <= '0;
                else if (push && s1_perr && (s1_tid == TID_W'(t)) && (cnt[t] != '1))
                    cnt[t] <= cnt[t] + 1'b1;
            end
        end
    end

    always_comb begin
        ecnt = '0;
        for (int t = 0; t < NUM_THR; t++) ecnt[t*ECNT_W +: ECNT_W] = cnt[t];
    end

    // Sticky first-error log. A clear coinciding with a new error leaves the
    // log holding that new error.
    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            elog_vld     <= 1'b0;
            elog_tid     <= '0;
            elog_is_data <= 1'b0;
        end else if (push && s1_perr && (!elog_vld || elog_clr)) begin
            elog_vld     <= 1'b1;
            elog_tid     <= s1_tid;
            elog_is_data <= s1_is_data;
        end else if (elog_clr) begin
            elog_vld     <= 1'b0;
            elog_tid     <= '0;
            elog_is_data <= 1'b0;
        end
    end

endmodule

// File: tb/tb_lsu_tlbdp_rdq.sv
// ---------------------------------------------------------------------------
// tb_lsu_tlbdp_rdq
//   Directed bench for lsu_tlbdp_rdq: tag/data formatting, parity errors,
//   counters, the first-error log, queue backpressure and ordering, and
//   reset while entries are queued. Define LSU_TLBDP_ERRINJ_EN to also
//   exercise parity error injection.
// ---------------------------------------------------------------------------
module tb_lsu_tlbdp_rdq;

    logic        rclk;
    logic        arst_l;
    logic        rd_vld;
    logic        rd_rdy;
    logic        rd_is_data;
    logic [1:0]  rd_tid;
    logic [58:0] tlb_tag;
    logic [42:0] tlb_data;
    logic        out_vld;
    logic        out_rdy;
    logic [63:0] out_data;
    logic [1:0]  out_tid;
    logic        out_perr;
    logic [15:0] ecnt;
    logic        elog_vld;
    logic [1:0]  elog_tid;
    logic        elog_is_data;
    logic [3:0]  err_clr;
    logic        elog_clr;
`ifdef LSU_TLBDP_ERRINJ_EN
    logic        inj_arm;
    logic        inj_is_data;
`endif

    int checks   = 0;
    int failures = 0;

    lsu_tlbdp_rdq dut (
        .rclk         (rclk),
        .arst_l       (arst_l),
        .rd_vld       (rd_vld),
        .rd_rdy       (rd_rdy),
        .rd_is_data   (rd_is_data),
        .rd_tid       (rd_tid),
        .tlb_tag      (tlb_tag),
        .tlb_data     (tlb_data),
`ifdef LSU_TLBDP_ERRINJ_EN
        .inj_arm      (inj_arm),
        .inj_is_data  (inj_is_data),
`endif
        .out_vld      (out_vld),
        .out_rdy      (out_rdy),
        .out_data     (out_data),
        .out_tid      (out_tid),
        .out_perr     (out_perr),
        .ecnt         (ecnt),
        .elog_vld     (elog_vld),
        .elog_tid     (elog_tid),
        .elog_is_data (elog_is_data),
        .err_clr      (err_clr),
        .elog_clr     (elog_clr)
    );

    // Free-running clock, 10 time units per cycle.
    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    // Advance one cycle and settle just after the rising edge.
    task automatic tick();
        @(posedge rclk);
        #1;
    endtask

    // Drive the read-return inputs for the coming edge.
    task automatic applyStimulus(input logic vld, input logic is_data,
                                 input logic [1:0] tid, input logic [58:0] tag,
                                 input logic [42:0] data);
        rd_vld     = vld;
        rd_is_data = is_data;
        rd_tid     = tid;
        tlb_tag    = tag;
        tlb_data   = data;
    endtask

    // One comparison: count it, and report a failure with tag and values.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Tag word with correct stored parity.
    function automatic logic [58:0] goodTag(input logic [57:0] v);
        return {^v, v};
    endfunction

    initial begin
        arst_l     = 1'b1;
        out_rdy    = 1'b1;
        err_clr    = 4'b0;
        elog_clr   = 1'b0;
`ifdef LSU_TLBDP_ERRINJ_EN
        inj_arm     = 1'b0;
        inj_is_data = 1'b0;
`endif
        applyStimulus(1'b0, 1'b0, 2'd0, 59'h0, 43'h0);

        // Reset state
        #1 arst_l = 1'b0;
        #2;
        checkOutput("rst_out_vld",  64'(out_vld),  64'd0);
        checkOutput("rst_out_data", out_data,      64'd0);
        checkOutput("rst_ecnt",     64'(ecnt),     64'd0);
        checkOutput("rst_elog_vld", 64'(elog_vld), 64'd0);
        @(posedge rclk);
        #1 arst_l = 1'b1;
        tick();
        checkOutput("rst_rd_rdy", 64'(rd_rdy), 64'd1);

        // 1: clean tag read, two-cycle latency to out_vld
        $display("[TB] tag read latency");
        applyStimulus(1'b1, 1'b0, 2'd2, 59'h0, 43'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 2'd0, 59'h0, 43'h0);
        checkOutput("t1_vld_early", 64'(out_vld), 64'd0);
        tick();
        checkOutput("t1_vld",  64'(out_vld),  64'd1);
        checkOutput("t1_data", out_data,      64'd0);
        checkOutput("t1_perr", 64'(out_perr), 64'd0);
        checkOutput("t1_tid",  64'(out_tid),  64'd2);
        tick();
        checkOutput("t1_popped", 64'(out_vld), 64'd0);
        checkOutput("t1_ecnt",   64'(ecnt),    64'd0);

        // 2: data read, select bits 011 -> page size 011
        $display("[TB] data read formatting");
        applyStimulus(1'b1, 1'b1, 2'd0, 59'h0, {^42'h0AB_CDEF_6000, 42'h0AB_CDEF_6000});
        tick();
        applyStimulus(1'b0, 1'b0, 2'd0, 59'h0, 43'h0);
        tick();
        checkOutput("t2_data", out_data,      64'h6000_00AB_CDEF_6000);
        checkOutput("t2_perr", 64'(out_perr), 64'd0);
        tick();

        // 3: data parity error on thread 1, then tag error on thread 3
        $display("[TB] parity errors and log");
        applyStimulus(1'b1, 1'b1, 2'd1, 59'h0, {1'b1, 42'h0});
        tick();
        applyStimulus(1'b0, 1'b0, 2'd0, 59'h0, 43'h0);
        tick();
        checkOutput("t3_perr",      64'(out_perr),     64'd1);
        checkOutput("t3_data",      out_data,          64'd0);
        checkOutput("t3_ecnt",      64'(ecnt),         64'h0010);
        checkOutput("t3_elog_vld",  64'(elog_vld),     64'd1);
        checkOutput("t3_elog_tid",  64'(elog_tid),     64'd1);
        checkOutput("t3_elog_type", 64'(elog_is_data), 64'd1);
        tick();
        applyStimulus(1'b1, 1'b0, 2'd3, {1'b1, 58'h0}, 43'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 2'd0, 59'h0, 43'h0);
        tick();
        checkOutput("t3b_perr",      64'(out_perr),     64'd1);
        checkOutput("t3b_ecnt",      64'(ecnt),         64'h1010);
        checkOutput("t3b_elog_tid",  64'(elog_tid),     64'd1);
        checkOutput("t3b_elog_type", 64'(elog_is_data), 64'd1);
        tick();

        // 4: backpressure, stable head, in-order drain
        $display("[TB] backpressure and ordering");
        out_rdy = 1'b0;
        applyStimulus(1'b1, 1'b0, 2'd0, goodTag(58'h11), 43'h0);
        checkOutput("t4_rdy_a", 64'(rd_rdy), 64'd1);
        tick();
        applyStimulus(1'b1, 1'b0, 2'd1, goodTag(58'h22), 43'h0);
        checkOutput("t4_rdy_b", 64'(rd_rdy), 64'd1);
        tick();
        applyStimulus(1'b1, 1'b0, 2'd2, goodTag(58'h33), 43'h0);
        checkOutput("t4_rdy_c0", 64'(rd_rdy), 64'd0);
        checkOutput("t4_head0",  out_data,    64'h11);
        tick();
        checkOutput("t4_rdy_c1", 64'(rd_rdy), 64'd0);
        checkOutput("t4_head1",  out_data,    64'h11);
        checkOutput("t4_tid1",   64'(out_tid), 64'd0);
        tick();
        checkOutput("t4_vld2",  64'(out_vld), 64'd1);
        checkOutput("t4_head2", out_data,     64'h11);
        out_rdy = 1'b1;
        #1;
        checkOutput("t4_rdy_pop", 64'(rd_rdy), 64'd1);
        tick();
        checkOutput("t4_pop_b",     out_data,      64'h22);
        checkOutput("t4_pop_b_tid", 64'(out_tid),  64'd1);
        applyStimulus(1'b1, 1'b0, 2'd3, goodTag(58'h44), 43'h0);
        checkOutput("t4_rdy_d", 64'(rd_rdy), 64'd1);
        tick();
        applyStimulus(1'b0, 1'b0, 2'd0, 59'h0, 43'h0);
        checkOutput("t4_pop_c",     out_data,     64'h33);
        checkOutput("t4_pop_c_tid", 64'(out_tid), 64'd2);
        tick();
        checkOutput("t4_pop_d",     out_data,     64'h44);
        checkOutput("t4_pop_d_tid", 64'(out_tid), 64'd3);
        tick();
        checkOutput("t4_empty", 64'(out_vld), 64'd0);

        // 5: counter saturation, then clear winning over an increment
        $display("[TB] counter saturation and clear");
        applyStimulus(1'b1, 1'b0, 2'd0, {1'b1, 58'h0}, 43'h0);
        repeat (20) tick();
        applyStimulus(1'b0, 1'b0, 2'd0, 59'h0, 43'h0);
        repeat (3) tick();
        checkOutput("t5_sat", 64'(ecnt), 64'h101F);
        applyStimulus(1'b1, 1'b0, 2'd0, {1'b1, 58'h0}, 43'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 2'd0, 59'h0, 43'h0);
        err_clr = 4'b0001;
        tick();
        err_clr = 4'b0000;
        checkOutput("t5_clr_wins", 64'(ecnt), 64'h1010);

        // Log clear together with a new error reloads the log
        applyStimulus(1'b1, 1'b0, 2'd2, {1'b1, 58'h0}, 43'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 2'd0, 59'h0, 43'h0);
        elog_clr = 1'b1;
        tick();
        elog_clr = 1'b0;
        checkOutput("t5_log_vld",  64'(elog_vld),     64'd1);
        checkOutput("t5_log_tid",  64'(elog_tid),     64'd2);
        checkOutput("t5_log_type", 64'(elog_is_data), 64'd0);
        checkOutput("t5_ecnt",     64'(ecnt),         64'h1110);
        elog_clr = 1'b1;
        tick();
        elog_clr = 1'b0;
        checkOutput("t5_log_clr", 64'(elog_vld), 64'd0);

        // 6: reset with two entries queued
        $display("[TB] reset while queued");
        out_rdy = 1'b0;
        applyStimulus(1'b1, 1'b0, 2'd1, goodTag(58'h55), 43'h0);
        tick();
        applyStimulus(1'b1, 1'b0, 2'd2, goodTag(58'h66), 43'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 2'd0, 59'h0, 43'h0);
        tick();
        checkOutput("t6_queued", 64'(out_vld), 64'd1);
        arst_l = 1'b0;
        #1;
        checkOutput("t6_vld",  64'(out_vld), 64'd0);
        checkOutput("t6_ecnt", 64'(ecnt),    64'd0);
        checkOutput("t6_data", out_data,     64'd0);
        checkOutput("t6_log",  64'(elog_vld), 64'd0);
        #2 arst_l = 1'b1;
        out_rdy = 1'b1;
        tick();
        checkOutput("t6_rdy",      64'(rd_rdy),  64'd1);
        checkOutput("t6_vld_post", 64'(out_vld), 64'd0);

`ifdef LSU_TLBDP_ERRINJ_EN
        // Error injection: one flipped tag parity, then back to clean
        $display("[TB] error injection");
        inj_arm     = 1'b1;
        inj_is_data = 1'b0;
        tick();
        inj_arm = 1'b0;
        applyStimulus(1'b1, 1'b0, 2'd0, goodTag(58'h77), 43'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 2'd0, 59'h0, 43'h0);
        tick();
        checkOutput("inj_perr", 64'(out_perr), 64'd1);
        tick();
        applyStimulus(1'b1, 1'b0, 2'd0, goodTag(58'h78), 43'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 2'd0, 59'h0, 43'h0);
        tick();
        checkOutput("inj_disarm", 64'(out_perr), 64'd0);
        tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
